// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: NCH register-file write channels plus HI/LO and LLbit,
// with stall/bubble/flush handling, same-address arbitration and a saturating retire counter.
module mem_wb_pipe #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NCH = 2,
   parameter int CW  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_mem,
   input  logic                stall_wb,
   input  logic                flush,
   input  logic [NCH*AW-1:0]   mem_wd,
   input  logic [NCH*DW-1:0]   mem_wdata,
   input  logic [NCH-1:0]      mem_wreg,
   input  logic                mem_whilo,
   input  logic [DW-1:0]       mem_hi,
   input  logic [DW-1:0]       mem_lo,
   input  logic                mem_llbit_we,
   input  logic                mem_llbit,
   input  logic                cnt_clr,
   output logic [NCH*AW-1:0]   wb_wd,
   output logic [NCH*DW-1:0]   wb_wdata,
   output logic [NCH-1:0]      wb_wreg,
   output logic                wb_whilo,
   output logic [DW-1:0]       wb_hi,
   output logic [DW-1:0]       wb_lo,
   output logic                wb_llbit_we,
   output logic                wb_llbit,
   output logic [CW-1:0]       retire_cnt
);

   logic [NCH*AW-1:0] r_wd;
   logic [NCH*DW-1:0] r_wdata;
   logic [NCH-1:0]    r_wreg;
   logic              r_whilo;
   logic [DW-1:0]     r_hi;
   logic [DW-1:0]     r_lo;
   logic              r_llbit_we;
   logic              r_llbit;
   logic [CW-1:0]     r_cnt;

   logic [NCH-1:0]    w_arb_wreg;
   logic [CW:0]       w_pop;
   logic [CW:0]       w_sum;
   logic [CW-1:0]     w_cnt_next;
   logic              w_pass;
   logic              w_bubble;

   assign w_pass   = !flush && !stall_mem && !stall_wb;
   assign w_bubble = flush || (stall_mem && !stall_wb);

   // A lower channel loses its enable when a higher channel writes the same nonzero address.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      w_arb_wreg = mem_wreg;
      for (int i = 0; i < NCH; i++) begin
         for (int j = i + 1; j < NCH; j++) begin
            if (mem_wreg[i] && mem_wreg[j] &&
                (mem_wd[i*AW +: AW] == mem_wd[j*AW +: AW]) &&
                (mem_wd[i*AW +: AW] != '0)) begin
               w_arb_wreg[i] = 1'b0;
            end
         end
      end
   end

   // One extra bit on the sum exposes overflow so the counter can pin at all-ones.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NCH; i++) begin
         w_pop = w_pop + {{CW{1'b0}}, w_arb_wreg[i]};
      end
      w_sum      = {1'b0, r_cnt} + w_pop;
      w_cnt_next = w_sum[CW] ? {CW{1'b1}} : w_sum[CW-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         r_wd       <= '0;
         r_wdata    <= '0;
         r_wreg     <= '0;
         r_whilo    <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_llbit_we <= 1'b0;
         r_llbit    <= 1'b0;
      end else if (!stall_wb) begin
         r_wd       <= mem_wd;
         r_wdata    <= mem_wdata;
         r_wreg     <= w_arb_wreg;
         r_whilo    <= mem_whilo;
         r_hi       <= mem_hi;
         r_lo       <= mem_lo;
         r_llbit_we <= mem_llbit_we;
         r_llbit    <= mem_llbit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_cnt <= '0;
      end else if (w_pass) begin
         r_cnt <= w_cnt_next;
      end
   end

   assign wb_wd       = r_wd;
   assign wb_wdata    = r_wdata;
   assign wb_wreg     = r_wreg;
   assign wb_whilo    = r_whilo;
   assign wb_hi       = r_hi;
   assign wb_lo       = r_lo;
   assign wb_llbit_we = r_llbit_we;
   assign wb_llbit    = r_llbit;
   assign retire_cnt  = r_cnt;

endmodule
